// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared op encodings and sizing helpers for the program counter unit
//
// Purpose:
//   Common definitions imported by pc_ret_stack and pc_stack_unit.
//   - OP_W and the OP_* localparams give the op encodings.
//     Values 6 and 7 are not listed here; the top decodes them as HOLD.
//   - depth_w() returns the width of a counter that can hold 0..DEPTH inclusive.
// Ports: none (package).

package pc_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_HOLD = 3'd0;
  localparam logic [OP_W-1:0] OP_INC  = 3'd1;
  localparam logic [OP_W-1:0] OP_LD   = 3'd2;
  localparam logic [OP_W-1:0] OP_BR   = 3'd3;
  localparam logic [OP_W-1:0] OP_CALL = 3'd4;
  localparam logic [OP_W-1:0] OP_RET  = 3'd5;

  // The counter must represent DEPTH itself (the full state), so it needs
  // one bit more than a pointer into a DEPTH-entry buffer.
  function automatic int depth_w(input int d);
    return $clog2(d) + 1;
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// rtl/pc_ret_stack.sv - circular return-address LIFO with separate depth count
//
// Purpose:
//   Return-address stack used by pc_stack_unit for CALL/RET and interrupts.
//   The storage is a circular buffer with a top pointer. A push while full
//   overwrites the oldest entry, because the pointer simply wraps. The depth
//   counter saturates at DEPTH.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset (clears pointer, depth, contents)
//   i_push   in   push i_din (takes precedence over i_pop)
//   i_pop    in   pop the top entry (ignored when empty)
//   i_din    in   W-bit value to push
//   o_top    out  W-bit entry at the top pointer
//   o_depth  out  number of valid entries (0..DEPTH)
//   o_full   out  o_depth == DEPTH
//   o_empty  out  o_depth == 0

module pc_ret_stack
  import pc_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_push,
  input  logic                      i_pop,
  input  logic [W-1:0]              i_din,
  output logic [W-1:0]              o_top,
  output logic [depth_w(DEPTH)-1:0] o_depth,
  output logic                      o_full,
  output logic                      o_empty
);

  localparam int DW = depth_w(DEPTH);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_ptr;
  logic [DW-1:0] r_depth;
  logic [PW-1:0] w_ptr_inc;
  logic [PW-1:0] w_ptr_dec;

  // DEPTH is a power of two, so plain pointer arithmetic wraps modulo DEPTH.
  assign w_ptr_inc = r_ptr + PW'(1);
  assign w_ptr_dec = r_ptr - PW'(1);

  assign o_top   = r_mem[r_ptr];
  assign o_depth = r_depth;
  assign o_full  = (r_depth == DW'(DEPTH));
  assign o_empty = (r_depth == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr   <= '0;
      r_depth <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_push) begin
      // When full, the slot past the top is the oldest entry; overwriting it
      // is exactly the discard-oldest behaviour.
      r_ptr            <= w_ptr_inc;
      r_mem[w_ptr_inc] <= i_din;
      if (!o_full) begin
        r_depth <= r_depth + DW'(1);
      end
    end else if (i_pop && !o_empty) begin
      r_ptr   <= w_ptr_dec;
      r_depth <= r_depth - DW'(1);
    end
  end

endmodule

// File: rtl/pc_stack_unit.sv
// rtl/pc_stack_unit.sv - program counter with branches, call/return stack and optional interrupt
//
// Purpose:
//   Holds the fetch program counter Q. One op per enabled cycle selects one update:
//     HOLD  - no change
//     INC   - step Q
//     LD    - load an absolute target
//     BR    - add a signed offset
//     CALL  - push the return address, then jump
//     RET   - pop the return address into Q
//   Ops 6 and 7 are treated as HOLD. Stack overflow and underflow set a
//   sticky err flag.
//   Optional feature macro: PC_IRQ_EN. When it is defined, the irq/irq_ack
//   ports exist and an interrupt pre-empts the op.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   en       in   advance enable; 0 holds Q, stack and err
//   op       in   OP_W-bit operation select
//   D        in   W-bit target (LD/CALL) or signed offset (BR)
//   Q        out  current program counter
//   depth    out  valid return-stack entries
//   full     out  depth == DEPTH
//   empty    out  depth == 0
//   err      out  sticky overflow/underflow flag
//   err_clr  in   clears err; acts even when en is low
//   irq      in   level interrupt request (PC_IRQ_EN only)
//   irq_ack  out  one-cycle pulse when the interrupt is taken (PC_IRQ_EN only)

module pc_stack_unit
  import pc_pkg::*;
#(
  parameter int             W         = 16,
  parameter int             STEP      = 2,
  parameter int             DEPTH     = 4,
  parameter logic [W-1:0]   RESET_VEC = '0,
  parameter logic [W-1:0]   IRQ_VEC   = W'(8)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [OP_W-1:0]           op,
  input  logic [W-1:0]              D,
  output logic [W-1:0]              Q,
  output logic [depth_w(DEPTH)-1:0] depth,
  output logic                      full,
  output logic                      empty,
  output logic                      err,
  input  logic                      err_clr
`ifdef PC_IRQ_EN
  ,
  input  logic                      irq,
  output logic                      irq_ack
`endif
);

  localparam int DW = depth_w(DEPTH);

  logic [W-1:0]  r_q;
  logic          r_err;
  logic [W-1:0]  w_q_nxt;
  logic [W-1:0]  w_q_inc;
  logic [W-1:0]  w_push_data;
  logic [W-1:0]  w_top;
  logic          w_push;
  logic          w_pop;
  logic          w_err_set;
  logic          w_full;
  logic          w_empty;
  logic          w_irq_take;
  logic [DW-1:0] w_depth;

  assign w_q_inc = r_q + W'(STEP);

`ifdef PC_IRQ_EN
  logic r_irq_armed;
  logic r_irq_ack;

  // The arm flop makes a level irq act like an edge. Once taken, the
  // interrupt stays blocked until irq has been seen low.
  assign w_irq_take = en & irq & r_irq_armed;
  assign irq_ack    = r_irq_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_irq_armed <= 1'b1;
      r_irq_ack   <= 1'b0;
    end else begin
      r_irq_ack <= w_irq_take;
      if (w_irq_take) begin
        r_irq_armed <= 1'b0;
      end else if (!irq) begin
        r_irq_armed <= 1'b1;
      end
    end
  end
`else
  assign w_irq_take = 1'b0;
`endif

  // Next-PC and stack-control mux.
  always_comb begin
    w_q_nxt     = r_q;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_push_data = w_q_inc;
    w_err_set   = 1'b0;
    if (w_irq_take) begin
      // The discarded instruction at Q becomes the return address.
      w_push      = 1'b1;
      w_push_data = r_q;
      w_q_nxt     = IRQ_VEC;
      w_err_set   = w_full;
    end else if (en) begin
      case (op)
        OP_INC:  w_q_nxt = w_q_inc;
        OP_LD:   w_q_nxt = D;
        OP_BR:   w_q_nxt = r_q + D;
        OP_CALL: begin
          w_push    = 1'b1;
          w_q_nxt   = D;
          w_err_set = w_full;
        end
        OP_RET: begin
          if (w_empty) begin
            // Underflow falls through to the next instruction.
            w_q_nxt   = w_q_inc;
            w_err_set = 1'b1;
          end else begin
            w_pop   = 1'b1;
            w_q_nxt = w_top;
          end
        end
        default: w_q_nxt = r_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q   <= RESET_VEC;
      r_err <= 1'b0;
    end else begin
      r_q <= w_q_nxt;
      // A new error in the same cycle as err_clr leaves err set.
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  pc_ret_stack #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_push_data),
    .o_top   (w_top),
    .o_depth (w_depth),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign Q     = r_q;
  assign err   = r_err;
  assign depth = w_depth;
  assign full  = w_full;
  assign empty = w_empty;

endmodule

// File: tb/tb_pc_stack_unit.sv
// tb/tb_pc_stack_unit.sv - scoreboard bench for pc_stack_unit against a queue-based reference model

module tb_pc_stack_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [2:0]  op;
  logic [15:0] D;
  logic [15:0] Q;
  logic [2:0]  depth;
  logic        full;
  logic        empty;
  logic        err;
  logic        err_clr;
`ifdef PC_IRQ_EN
  logic        irq;
  logic        irq_ack;
`endif

  pc_stack_unit #(
    .W(16), .STEP(2), .DEPTH(4), .RESET_VEC(16'h0000), .IRQ_VEC(16'h0008)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .op      (op),
    .D       (D),
    .Q       (Q),
    .depth   (depth),
    .full    (full),
    .empty   (empty),
    .err     (err),
    .err_clr (err_clr)
`ifdef PC_IRQ_EN
    ,
    .irq     (irq),
    .irq_ack (irq_ack)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned tag;
    logic [15:0] q;
    int          dep;
    bit          ack;
    bit          err;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  // Reference model state: the stack is a plain queue, newest at the back.
  logic [15:0] m_q;
  logic [15:0] m_stk[$];
  bit          m_err;
  bit          m_armed;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: each expected entry is checked at the first falling edge after
  // the rising edge that applied its stimulus.
  always @(negedge clk) begin
    exp_t e;
    if (rst && sb.size() > 0 && sb[0].tag < cyc) begin
      e = sb.pop_front();
      chk("Q", 32'(Q), 32'(e.q));
      chk("depth", 32'(depth), 32'(e.dep));
      chk("full", 32'(full), 32'(e.dep == 4));
      chk("empty", 32'(empty), 32'(e.dep == 0));
      chk("err", 32'(err), 32'(e.err));
`ifdef PC_IRQ_EN
      chk("irq_ack", 32'(irq_ack), 32'(e.ack));
`endif
    end
  end

  function automatic bit push_ra(input logic [15:0] v);
    bit ovf = 1'b0;
    if (m_stk.size() == 4) begin
      void'(m_stk.pop_front());
      ovf = 1'b1;
    end
    m_stk.push_back(v);
    return ovf;
  endfunction

  function automatic void model_reset();
    m_q = 16'h0000;
    m_stk.delete();
    m_err = 1'b0;
    m_armed = 1'b1;
  endfunction

  task automatic issue(input bit e, input logic [2:0] o, input logic [15:0] d,
                       input bit clr, input bit ir);
    exp_t x;
    bit   take = 1'b0;
    bit   eset = 1'b0;
    @(posedge clk);
    #1;
    en = e; op = o; D = d; err_clr = clr;
`ifdef PC_IRQ_EN
    irq = ir;
    take = e && ir && m_armed;
    if (take) m_armed = 1'b0;
    else if (!ir) m_armed = 1'b1;
`else
    if (ir) take = 1'b0;
`endif
    if (take) begin
      eset = push_ra(m_q);
      m_q = 16'h0008;
    end else if (e) begin
      case (o)
        3'd1: m_q = m_q + 16'd2;
        3'd2: m_q = d;
        3'd3: m_q = m_q + d;
        3'd4: begin eset = push_ra(m_q + 16'd2); m_q = d; end
        3'd5: begin
          if (m_stk.size() == 0) begin m_q = m_q + 16'd2; eset = 1'b1; end
          else m_q = m_stk.pop_back();
        end
        default: ;
      endcase
    end
    if (eset) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    x.tag = cyc; x.q = m_q; x.dep = m_stk.size(); x.ack = take; x.err = m_err;
    sb.push_back(x);
  endtask

  task automatic drain();
    issue(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_Q", 32'(Q), 32'h0);
    chk("rst_depth", 32'(depth), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic rand_ops(input int n);
    for (int i = 0; i < n; i++) begin
      issue($urandom_range(0, 7) != 0, 3'($urandom_range(0, 7)), 16'($urandom),
            $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; op = 3'd0; D = 16'h0; err_clr = 1'b0;
`ifdef PC_IRQ_EN
    irq = 1'b0;
`endif
    model_reset();
    #1;
    chk("init_Q", 32'(Q), 32'h0);
    chk("init_depth", 32'(depth), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // INC x3 from reset
    repeat (3) issue(1'b1, 3'd1, 16'h0, 1'b0, 1'b0);
    drain();
    chk("inc3", 32'(Q), 32'h6);

    // BR wrap, then INC wraps to zero
    issue(1'b1, 3'd2, 16'h0004, 1'b0, 1'b0);
    issue(1'b1, 3'd3, 16'hFFFA, 1'b0, 1'b0);
    drain();
    chk("br_wrap", 32'(Q), 32'hFFFE);
    issue(1'b1, 3'd1, 16'h0, 1'b0, 1'b0);
    drain();
    chk("inc_wrap", 32'(Q), 32'h0);

    // Call / return
    issue(1'b1, 3'd2, 16'h0010, 1'b0, 1'b0);
    issue(1'b1, 3'd4, 16'h0200, 1'b0, 1'b0);
    drain();
    chk("call_Q", 32'(Q), 32'h0200);
    chk("call_depth", 32'(depth), 32'd1);
    issue(1'b1, 3'd5, 16'h0, 1'b0, 1'b0);
    drain();
    chk("ret_Q", 32'(Q), 32'h0012);
    chk("ret_empty", 32'(empty), 32'd1);

    // Overflow then LIFO returns then underflow
    issue(1'b1, 3'd2, 16'h1000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) issue(1'b1, 3'd4, 16'(16'h2000 + 16'h100 * i), 1'b0, 1'b0);
    drain();
    chk("ovf_err", 32'(err), 32'd1);
    chk("ovf_depth", 32'(depth), 32'd4);
    for (int i = 0; i < 4; i++) issue(1'b1, 3'd5, 16'h0, 1'b0, 1'b0);
    drain();
    chk("lifo_last", 32'(Q), 32'h2002);
    issue(1'b1, 3'd5, 16'h0, 1'b0, 1'b0);
    drain();
    chk("udf_Q", 32'(Q), 32'h2004);
    chk("udf_err", 32'(err), 32'd1);
    issue(1'b1, 3'd0, 16'h0, 1'b1, 1'b0);
    drain();
    chk("err_clr", 32'(err), 32'd0);

    // Hold with en low; err_clr still acts
    issue(1'b1, 3'd5, 16'h0, 1'b0, 1'b0);
    issue(1'b0, 3'd4, 16'h1234, 1'b0, 1'b0);
    drain();
    chk("hold_Q", 32'(Q), 32'h2006);
    chk("hold_err", 32'(err), 32'd1);
    issue(1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
    drain();
    chk("hold_clr", 32'(err), 32'd0);

`ifdef PC_IRQ_EN
    issue(1'b1, 3'd2, 16'h0100, 1'b0, 1'b0);
    issue(1'b1, 3'd2, 16'h0555, 1'b0, 1'b1);
    issue(1'b1, 3'd1, 16'h0, 1'b0, 1'b1);
    issue(1'b1, 3'd5, 16'h0, 1'b0, 1'b0);
    drain();
    chk("irq_ret", 32'(Q), 32'h0100);
`endif

    rand_ops(250);
    drain();

    // Asynchronous reset mid-run from a non-reset state
    issue(1'b1, 3'd2, 16'h1234, 1'b0, 1'b0);
    issue(1'b1, 3'd4, 16'h4000, 1'b0, 1'b0);
    drain();
    async_reset();
    repeat (3) issue(1'b1, 3'd1, 16'h0, 1'b0, 1'b0);
    drain();
    chk("rst_inc3", 32'(Q), 32'h6);

    rand_ops(250);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
Next-generation program counter for the Minx-class cores. It adds parametrised address width and instruction step, PC-relative branches, and call/return through an internal return-address stack. It sits between the decoder/branch unit and the instruction-fetch address port, and replaces the plain load/increment counter. A single opcode per cycle selects the update.

Parameters:
W, 16, address width in bits (8..32)
STEP, 2, bytes added per sequential increment (W/8 for existing cores)
DEPTH, 4, return-address stack entries (power of two, 2..16)
RESET_VEC, 0, value loaded into Q on reset
IRQ_VEC, 'h0008, interrupt vector address (used only with PC_IRQ_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
en  in  1  advance enable; 0 = hold everything regardless of op
op  in  3  0 HOLD, 1 INC, 2 LD, 3 BR, 4 CALL, 5 RET, 6/7 treated as HOLD
D  in  W  absolute target (LD/CALL) or two's-complement offset (BR)
Q  out  W  current program counter
depth  out  $clog2(DEPTH)+1  number of valid stack entries
full  out  1  depth == DEPTH
empty  out  1  depth == 0
err  out  1  sticky stack overflow/underflow flag
err_clr  in  1  synchronous clear of err
irq  in  1  interrupt request, level (PC_IRQ_EN only)
irq_ack  out  1  one-cycle pulse when interrupt taken (PC_IRQ_EN only)

Behaviour:
- Reset is asynchronous and active-low: rst==0 forces Q=RESET_VEC, depth=0, err=0, irq_ack=0, and invalidates the stack contents. Release is synchronous to clk.
- All updates are registered. The new Q is visible one cycle after the op is sampled, and the stack top is visible the same cycle.
- en==0: Q, stack, depth, and err (except err_clr) hold. err_clr acts regardless of en.
- INC: Q <= Q + STEP, modulo 2^W.
- LD: Q <= D.
- BR: Q <= Q + D, with D signed and the sum wrapping modulo 2^W. There is no saturation.
- CALL: push (Q + STEP) mod 2^W, then Q <= D.
  - If full, the oldest entry is discarded (circular stack), depth stays DEPTH, and err <= 1.
- RET: Q <= top, pop, depth decrements.
  - If empty, Q <= Q + STEP, depth stays 0, and err <= 1.
- err_clr in the same cycle as a new error: the set wins.
- The stack is implemented as a circular buffer with a top pointer. The pointer wraps modulo DEPTH, and depth is tracked separately.
- full and empty are combinational from the depth register.

Optional Feature:
PC_IRQ_EN
- Defined: irq and irq_ack ports exist. When irq==1 and en==1, the interrupt takes priority over op, which is discarded that cycle.
  - The unit pushes the current Q (the address of the discarded instruction) and sets Q <= IRQ_VEC.
  - irq_ack pulses high for exactly that cycle.
  - Overflow rules are identical to CALL.
  - The interrupt is not re-taken until irq has been sampled low for at least one cycle (edge arm flop, reset to armed).
- Not defined: the ports are absent, and the logic and arm flop are not synthesised.

Decomposition:
- Package pc_pkg holds:
  - localparams for the op encodings (OP_HOLD..OP_RET)
  - the op width (3)
  - a function computing the depth counter width
- Sub-module pc_ret_stack holds the circular LIFO. It provides push, pop, din, top, depth, full, and empty, with the same clk and rst. pc_stack_unit owns the Q register, the next-PC mux, the err flag, and the optional IRQ logic.

Test Plan:
- Reset: with rst low mid-run, Q goes to RESET_VEC=0 and depth to 0 within the same cycle, asynchronously. After release, INC x3 gives Q=6 with STEP=2.
- BR wrap: Q=0x0004, BR with D=0xFFFA (-6) gives Q=0xFFFE. A following INC gives Q=0x0000.
- Call/return: Q=0x0010, CALL D=0x0200 gives Q=0x0200, depth=1, top=0x0012. RET gives Q=0x0012, depth=0, empty=1.
- Overflow: 5 nested CALLs with DEPTH=4 give err=1 and depth=4. Four RETs return the last four return addresses in LIFO order. A fifth RET (underflow) gives Q=prev+2 and err stays 1. err_clr gives err=0.
- Hold: en=0 with op=CALL leaves Q, depth, and err unchanged. en=0 with err_clr=1 clears err.
- PC_IRQ_EN: Q=0x0100, irq=1 with op=LD gives Q=0x0008, a one-cycle irq_ack pulse, and top=0x0100. Holding irq high does not retrigger. RET gives Q=0x0100.
